// File: rtl/fx_chain_pipeline.sv
// Four-register effects chain: input gain, selectable hard/soft clipper, output volume.
// Every sample travels with its own parameter snapshot and clip flag; a sticky saturating counter tallies clipped outputs.
module fx_chain_pipeline #(
    parameter int unsigned IN_W      = 12,
    parameter int unsigned FXP_W     = 16,
    parameter int unsigned GAIN_W    = 11,
    parameter int unsigned GAIN_FRAC = 4,
    parameter int unsigned VOL_W     = 8,
    parameter int unsigned VOL_FRAC  = 7,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_sample,
    input  logic [GAIN_W-1:0]       i_par_gain,
    input  logic [1:0]              i_par_mode,
    input  logic [FXP_W-2:0]        i_par_thresh,
    input  logic [VOL_W-1:0]        i_par_vol,
    input  logic                    i_clip_clr,
    output logic signed [FXP_W-1:0] o_sample,
    output logic                    o_valid,
    output logic                    o_clip,
    output logic [CNT_W-1:0]        o_clip_cnt
);

    localparam int unsigned G_PROD_W = FXP_W + GAIN_W + 1;
    localparam int unsigned V_PROD_W = FXP_W + VOL_W + 1;
    localparam int unsigned MAG_W    = FXP_W + 1;

    localparam logic signed [FXP_W-1:0]    X_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam logic signed [FXP_W-1:0]    X_MIN = {1'b1, {(FXP_W-1){1'b0}}};
    localparam logic signed [G_PROD_W-1:0] G_MAX = G_PROD_W'(X_MAX);
    localparam logic signed [G_PROD_W-1:0] G_MIN = G_PROD_W'(X_MIN);
    localparam logic signed [V_PROD_W-1:0] V_MAX = V_PROD_W'(X_MAX);
    localparam logic signed [V_PROD_W-1:0] V_MIN = V_PROD_W'(X_MIN);
    localparam logic signed [MAG_W-1:0]    M_MAX = MAG_W'(X_MAX);
    localparam logic signed [MAG_W-1:0]    M_MIN = MAG_W'(X_MIN);
    localparam logic [CNT_W-1:0]           CNT_MAX = {CNT_W{1'b1}};

    // S0: sign-extended sample plus parameter snapshot
    logic                    s0_valid_q;
    logic signed [FXP_W-1:0] s0_x_q;
    logic [GAIN_W-1:0]       s0_gain_q;
    logic [1:0]              s0_mode_q;
    logic [FXP_W-2:0]        s0_thresh_q;
    logic [VOL_W-1:0]        s0_vol_q;

    // S1: gained sample
    logic                    s1_valid_q;
    logic signed [FXP_W-1:0] s1_x_q, s1_x_d;
    logic                    s1_clip_q, s1_clip_d;
    logic [1:0]              s1_mode_q;
    logic [FXP_W-2:0]        s1_thresh_q;
    logic [VOL_W-1:0]        s1_vol_q;

    // S2: clipped sample
    logic                    s2_valid_q;
    logic signed [FXP_W-1:0] s2_x_q, s2_x_d;
    logic                    s2_clip_q, s2_clip_d;
    logic [VOL_W-1:0]        s2_vol_q;

    // Output stage
    logic signed [FXP_W-1:0] out_x_q, out_x_d;
    logic                    out_valid_q;
    logic                    out_clip_q, out_clip_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [G_PROD_W-1:0] g_a, g_b, g_prod, g_shift;
    logic signed [V_PROD_W-1:0] v_a, v_b, v_prod, v_shift;
    logic                       neg;
    logic [MAG_W-1:0]           mag, thr, mag_o;
    logic signed [MAG_W-1:0]    smag, res;

    // S1 gain: signed x unsigned, floor shift, saturate
    always_comb begin
        g_a       = G_PROD_W'(s0_x_q);
        g_b       = G_PROD_W'({1'b0, s0_gain_q});
        g_prod    = g_a * g_b;
        g_shift   = g_prod >>> GAIN_FRAC;
        s1_clip_d = 1'b0;
        s1_x_d    = FXP_W'(g_shift);
        if (g_shift > G_MAX) begin
            s1_x_d    = X_MAX;
            s1_clip_d = 1'b1;
        end else if (g_shift < G_MIN) begin
            s1_x_d    = X_MIN;
            s1_clip_d = 1'b1;
        end
    end

    // S2 clipper in sign-magnitude so the most negative level has a representable magnitude
    always_comb begin
        neg  = s1_x_q[FXP_W-1];
        mag  = neg ? -MAG_W'(s1_x_q) : MAG_W'(s1_x_q);
        thr  = MAG_W'(s1_thresh_q);
        mag_o = mag;
        case (s1_mode_q)
            2'b00:   mag_o = mag;
            2'b10:   mag_o = (mag > thr) ? thr + ((mag - thr) >> 2) : mag;
            default: mag_o = (mag > thr) ? thr : mag;
        endcase
        smag = mag_o;
        res  = neg ? -smag : smag;
        if (res > M_MAX) begin
            s2_x_d = X_MAX;
        end else if (res < M_MIN) begin
            s2_x_d = X_MIN;
        end else begin
            s2_x_d = FXP_W'(res);
        end
        s2_clip_d = s1_clip_q | (s2_x_d != s1_x_q);
    end

    // S3 volume feeding the output register directly
    always_comb begin
        v_a        = V_PROD_W'(s2_x_q);
        v_b        = V_PROD_W'({1'b0, s2_vol_q});
        v_prod     = v_a * v_b;
        v_shift    = v_prod >>> VOL_FRAC;
        out_clip_d = s2_clip_q;
        out_x_d    = FXP_W'(v_shift);
        if (v_shift > V_MAX) begin
            out_x_d    = X_MAX;
            out_clip_d = 1'b1;
        end else if (v_shift < V_MIN) begin
            out_x_d    = X_MIN;
            out_clip_d = 1'b1;
        end
    end

    // Clear wins over a coincident clip event
    always_comb begin
        cnt_d = cnt_q;
        if (i_clip_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_clip_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_x_q      <= '0;
            s0_gain_q   <= '0;
            s0_mode_q   <= '0;
            s0_thresh_q <= '0;
            s0_vol_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_clip_q   <= 1'b0;
            s1_mode_q   <= '0;
            s1_thresh_q <= '0;
            s1_vol_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_clip_q   <= 1'b0;
            s2_vol_q    <= '0;
            out_x_q     <= '0;
            out_valid_q <= 1'b0;
            out_clip_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s0_valid_q  <= i_valid;
            s1_valid_q  <= s0_valid_q;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            out_clip_q  <= s2_valid_q & out_clip_d;
            cnt_q       <= cnt_d;
            if (i_valid) begin
                s0_x_q      <= FXP_W'(i_sample);
                s0_gain_q   <= i_par_gain;
                s0_mode_q   <= i_par_mode;
                s0_thresh_q <= i_par_thresh;
                s0_vol_q    <= i_par_vol;
            end
            if (s0_valid_q) begin
                s1_x_q      <= s1_x_d;
                s1_clip_q   <= s1_clip_d;
                s1_mode_q   <= s0_mode_q;
                s1_thresh_q <= s0_thresh_q;
                s1_vol_q    <= s0_vol_q;
            end
            if (s1_valid_q) begin
                s2_x_q    <= s2_x_d;
                s2_clip_q <= s2_clip_d;
                s2_vol_q  <= s1_vol_q;
            end
            if (s2_valid_q) begin
                out_x_q <= out_x_d;
            end
        end
    end

    assign o_sample   = out_x_q;
    assign o_valid    = out_valid_q;
    assign o_clip     = out_clip_q;
    assign o_clip_cnt = cnt_q;

endmodule
